// File: rtl/rbcp_reg_responder_if.sv
// RBCP local-bus signal bundle between an RBCP initiator and a register responder.
// The initiator drives the strobes, address and write data; the responder answers with ACK and read data.
interface rbcp_reg_responder_if;
   logic        LOC_ACT;
   logic [31:0] LOC_ADDR;
   logic [7:0]  LOC_WD;
   logic        LOC_WE;
   logic        LOC_RE;
   logic        LOC_ACK;
   logic [7:0]  LOC_RD;

   modport master (
      output LOC_ACT, LOC_ADDR, LOC_WD, LOC_WE, LOC_RE,
      input  LOC_ACK, LOC_RD
   );

   modport slave (
      input  LOC_ACT, LOC_ADDR, LOC_WD, LOC_WE, LOC_RE,
      output LOC_ACK, LOC_RD
   );
endinterface

// File: rtl/rbcp_reg_responder.sv
// RBCP register responder: NUM_REGS read/write byte registers followed by NUM_REGS read-only
// status bytes, acknowledged a fixed ACK_LATENCY cycles after each accepted strobe.
module rbcp_reg_responder #(
   parameter logic [31:0] BASE_ADDR   = 32'hFFFF_0000,
   parameter int          NUM_REGS    = 16,
   parameter int          ACK_LATENCY = 2,
   parameter logic [7:0]  REG_DEFAULT = 8'h00
) (
   input  logic                    CLK,
   input  logic                    RSTn,
   rbcp_reg_responder_if.slave     loc,
   input  logic [8*NUM_REGS-1:0]   STATUS_IN,
   output logic [8*NUM_REGS-1:0]   REG_OUT,
   output logic [NUM_REGS-1:0]     REG_WR
);

   typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

   state_t      state, next_state;
   logic [3:0]  cnt;
   logic [7:0]  lat_offset;
   logic [7:0]  lat_wd;
   logic        lat_we;
   logic [7:0]  regs [NUM_REGS];
   logic [7:0]  rd_sel;
   logic [31:0] offset;
   logic        mapped;
   logic        accept;

   // Addresses below BASE_ADDR wrap to huge offsets and therefore fall outside the map.
   assign offset = loc.LOC_ADDR - BASE_ADDR;
   assign mapped = offset < 32'(2 * NUM_REGS);
   assign accept = (state == IDLE) && loc.LOC_ACT && (loc.LOC_WE || loc.LOC_RE) && mapped;

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (accept) next_state = (ACK_LATENCY == 1) ? ACK : WAIT;
         WAIT: begin
            // Losing LOC_ACT mid-wait aborts the transaction before it can commit.
            if (!loc.LOC_ACT)                          next_state = IDLE;
            else if (cnt == 4'(ACK_LATENCY - 2))       next_state = ACK;
         end
         ACK:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         cnt        <= 4'd0;
         lat_offset <= 8'h00;
         lat_wd     <= 8'h00;
         lat_we     <= 1'b0;
      end else begin
         if (accept) begin
            lat_offset <= offset[7:0];
            lat_wd     <= loc.LOC_WD;
            lat_we     <= loc.LOC_WE;
         end
         if (state == WAIT) cnt <= cnt + 4'd1;
         else               cnt <= 4'd0;
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         for (int k = 0; k < NUM_REGS; k++) regs[k] <= REG_DEFAULT;
      end else if (state == ACK && lat_we) begin
         for (int k = 0; k < NUM_REGS; k++)
            if (lat_offset == 8'(k)) regs[k] <= lat_wd;
      end
   end

   // A combined WE+RE strobe was latched as a write, so read data stays zero for it.
   always_comb begin
      rd_sel  = 8'h00;
      REG_OUT = '0;
      REG_WR  = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         if (lat_offset == 8'(k))            rd_sel = regs[k];
         if (lat_offset == 8'(NUM_REGS + k)) rd_sel = STATUS_IN[8*k +: 8];
         REG_OUT[8*k +: 8] = regs[k];
         REG_WR[k] = (state == ACK) && lat_we && (lat_offset == 8'(k));
      end
      loc.LOC_ACK = (state == ACK);
      loc.LOC_RD  = (state == ACK && !lat_we) ? rd_sel : 8'h00;
   end

endmodule

// File: tb/tb_rbcp_reg_responder.sv
// Directed self-checking bench for rbcp_reg_responder: default build plus an ACK_LATENCY=1 build.
module tb_rbcp_reg_responder;

   logic          CLK = 1'b0;
   logic          RSTn;
   logic [127:0]  status_in;
   logic [127:0]  reg_out;
   logic [15:0]   reg_wr;
   logic [127:0]  status_in1;
   logic [127:0]  reg_out1;
   logic [15:0]   reg_wr1;
   logic [127:0]  exp_reg_out;
   logic [127:0]  exp_reg_out1;
   int            tests_run = 0;
   int            tests_failed = 0;

   rbcp_reg_responder_if bus ();
   rbcp_reg_responder_if bus1 ();

   rbcp_reg_responder dut (
      .CLK(CLK), .RSTn(RSTn), .loc(bus),
      .STATUS_IN(status_in), .REG_OUT(reg_out), .REG_WR(reg_wr)
   );

   rbcp_reg_responder #(.ACK_LATENCY(1)) dut1 (
      .CLK(CLK), .RSTn(RSTn), .loc(bus1),
      .STATUS_IN(status_in1), .REG_OUT(reg_out1), .REG_WR(reg_wr1)
   );

   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RSTn = 1'b0;
      step();
      step();
      tests_run++;
      if (bus.LOC_ACK !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_ack: got %b, expected 0", bus.LOC_ACK); end
      tests_run++;
      if (bus.LOC_RD !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_rd: got %h, expected 00", bus.LOC_RD); end
      tests_run++;
      if (reg_wr !== 16'h0000) begin tests_failed++; $display("[TB] FAIL reset_reg_wr: got %h, expected 0000", reg_wr); end
      tests_run++;
      if (reg_out !== exp_reg_out) begin tests_failed++; $display("[TB] FAIL reset_reg_out: got %h, expected %h", reg_out, exp_reg_out); end
      RSTn = 1'b1;
   endtask

   // Strobe is launched right after reset release, so the first active edge must accept it.
   task automatic test_write();
      bus.LOC_ADDR = 32'hFFFF_0003; bus.LOC_WD = 8'hA5; bus.LOC_WE = 1'b1;
      step();
      bus.LOC_WE = 1'b0;
      tests_run++;
      if (bus.LOC_ACK !== 1'b0) begin tests_failed++; $display("[TB] FAIL write_ack_early: got %b, expected 0", bus.LOC_ACK); end
      step();
      tests_run++;
      if (bus.LOC_ACK !== 1'b1) begin tests_failed++; $display("[TB] FAIL write_ack: got %b, expected 1", bus.LOC_ACK); end
      tests_run++;
      if (reg_wr !== 16'h0008) begin tests_failed++; $display("[TB] FAIL write_reg_wr: got %h, expected 0008", reg_wr); end
      tests_run++;
      if (bus.LOC_RD !== 8'h00) begin tests_failed++; $display("[TB] FAIL write_rd: got %h, expected 00", bus.LOC_RD); end
      exp_reg_out[31:24] = 8'hA5;
      step();
      tests_run++;
      if (bus.LOC_ACK !== 1'b0 || reg_wr !== 16'h0000) begin tests_failed++; $display("[TB] FAIL write_after: got ack %b wr %h, expected 0 0000", bus.LOC_ACK, reg_wr); end
      tests_run++;
      if (reg_out !== exp_reg_out) begin tests_failed++; $display("[TB] FAIL write_reg_out: got %h, expected %h", reg_out, exp_reg_out); end
   endtask

   task automatic test_read();
      bus.LOC_ADDR = 32'hFFFF_0012; bus.LOC_RE = 1'b1;
      tests_run++;
      if (bus.LOC_RD !== 8'h00) begin tests_failed++; $display("[TB] FAIL status_rd_before: got %h, expected 00", bus.LOC_RD); end
      step();
      bus.LOC_RE = 1'b0;
      tests_run++;
      if (bus.LOC_ACK !== 1'b0 || bus.LOC_RD !== 8'h00) begin tests_failed++; $display("[TB] FAIL status_wait: got ack %b rd %h, expected 0 00", bus.LOC_ACK, bus.LOC_RD); end
      step();
      tests_run++;
      if (bus.LOC_ACK !== 1'b1 || bus.LOC_RD !== 8'h3C) begin tests_failed++; $display("[TB] FAIL status_rd: got ack %b rd %h, expected 1 3c", bus.LOC_ACK, bus.LOC_RD); end
      step();
      tests_run++;
      if (bus.LOC_ACK !== 1'b0 || bus.LOC_RD !== 8'h00) begin tests_failed++; $display("[TB] FAIL status_rd_after: got ack %b rd %h, expected 0 00", bus.LOC_ACK, bus.LOC_RD); end
      bus.LOC_ADDR = 32'hFFFF_0003; bus.LOC_RE = 1'b1;
      step();
      bus.LOC_RE = 1'b0;
      step();
      tests_run++;
      if (bus.LOC_ACK !== 1'b1 || bus.LOC_RD !== 8'hA5) begin tests_failed++; $display("[TB] FAIL reg_rd: got ack %b rd %h, expected 1 a5", bus.LOC_ACK, bus.LOC_RD); end
      step();
   endtask

   task automatic test_unmapped();
      logic [31:0] addrs [3];
      logic        wes   [3];
      int          n_ack;
      addrs[0] = 32'hFFFF_0020; wes[0] = 1'b0;
      addrs[1] = 32'hFFFE_FFFF; wes[1] = 1'b0;
      addrs[2] = 32'hFFFF_0020; wes[2] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.LOC_ADDR = addrs[i]; bus.LOC_WD = 8'hEE;
         bus.LOC_WE = wes[i]; bus.LOC_RE = !wes[i];
         step();
         bus.LOC_WE = 1'b0; bus.LOC_RE = 1'b0;
         n_ack = 0;
         for (int c = 0; c < 20; c++) begin
            if (bus.LOC_ACK === 1'b1) n_ack++;
            step();
         end
         tests_run++;
         if (n_ack !== 0) begin tests_failed++; $display("[TB] FAIL unmapped_ack[%0d]: got %0d acks, expected 0", i, n_ack); end
      end
      tests_run++;
      if (reg_out !== exp_reg_out) begin tests_failed++; $display("[TB] FAIL unmapped_regs: got %h, expected %h", reg_out, exp_reg_out); end
   endtask

   task automatic test_abort();
      int n_ack = 0;
      int n_wr  = 0;
      bus.LOC_ADDR = 32'hFFFF_0000; bus.LOC_WD = 8'h11; bus.LOC_WE = 1'b1;
      step();
      bus.LOC_WE = 1'b0; bus.LOC_ACT = 1'b0;
      for (int c = 0; c < 6; c++) begin
         if (bus.LOC_ACK === 1'b1) n_ack++;
         if (reg_wr !== 16'h0000) n_wr++;
         step();
      end
      bus.LOC_ACT = 1'b1;
      tests_run++;
      if (n_ack !== 0 || n_wr !== 0) begin tests_failed++; $display("[TB] FAIL abort: got %0d acks %0d wr, expected 0 0", n_ack, n_wr); end
      tests_run++;
      if (reg_out !== exp_reg_out) begin tests_failed++; $display("[TB] FAIL abort_regs: got %h, expected %h", reg_out, exp_reg_out); end
   endtask

   // The second strobe lands while the first is still waiting and must not replace it.
   task automatic test_simultaneous();
      int n_ack = 0;
      bus.LOC_ADDR = 32'hFFFF_0005; bus.LOC_WD = 8'h77; bus.LOC_WE = 1'b1; bus.LOC_RE = 1'b1;
      step();
      bus.LOC_WE = 1'b0;
      bus.LOC_ADDR = 32'hFFFF_0003; bus.LOC_WD = 8'h22;
      step();
      bus.LOC_RE = 1'b0;
      tests_run++;
      if (bus.LOC_ACK !== 1'b1 || bus.LOC_RD !== 8'h00) begin tests_failed++; $display("[TB] FAIL simul_ack: got ack %b rd %h, expected 1 00", bus.LOC_ACK, bus.LOC_RD); end
      tests_run++;
      if (reg_wr !== 16'h0020) begin tests_failed++; $display("[TB] FAIL simul_reg_wr: got %h, expected 0020", reg_wr); end
      exp_reg_out[47:40] = 8'h77;
      for (int c = 0; c < 10; c++) begin
         step();
         if (bus.LOC_ACK === 1'b1) n_ack++;
      end
      tests_run++;
      if (n_ack !== 0) begin tests_failed++; $display("[TB] FAIL simul_extra_ack: got %0d acks, expected 0", n_ack); end
      tests_run++;
      if (reg_out !== exp_reg_out) begin tests_failed++; $display("[TB] FAIL simul_regs: got %h, expected %h", reg_out, exp_reg_out); end
   endtask

   task automatic test_act_drop_in_ack();
      bus.LOC_ADDR = 32'hFFFF_0004; bus.LOC_WD = 8'h99; bus.LOC_WE = 1'b1;
      step();
      bus.LOC_WE = 1'b0;
      step();
      bus.LOC_ACT = 1'b0;
      #1;
      tests_run++;
      if (bus.LOC_ACK !== 1'b1 || reg_wr !== 16'h0010) begin tests_failed++; $display("[TB] FAIL actdrop_ack: got ack %b wr %h, expected 1 0010", bus.LOC_ACK, reg_wr); end
      step();
      bus.LOC_ACT = 1'b1;
      exp_reg_out[39:32] = 8'h99;
      tests_run++;
      if (reg_out !== exp_reg_out) begin tests_failed++; $display("[TB] FAIL actdrop_regs: got %h, expected %h", reg_out, exp_reg_out); end
   endtask

   task automatic test_back_to_back();
      bus.LOC_ADDR = 32'hFFFF_0002; bus.LOC_WD = 8'h33; bus.LOC_WE = 1'b1;
      step();
      bus.LOC_WE = 1'b0;
      step();
      tests_run++;
      if (bus.LOC_ACK !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_first_ack: got %b, expected 1", bus.LOC_ACK); end
      step();
      bus.LOC_RE = 1'b1;
      step();
      bus.LOC_RE = 1'b0;
      tests_run++;
      if (bus.LOC_ACK !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_wait: got %b, expected 0", bus.LOC_ACK); end
      step();
      tests_run++;
      if (bus.LOC_ACK !== 1'b1 || bus.LOC_RD !== 8'h33) begin tests_failed++; $display("[TB] FAIL b2b_read: got ack %b rd %h, expected 1 33", bus.LOC_ACK, bus.LOC_RD); end
      exp_reg_out[23:16] = 8'h33;
      step();
   endtask

   task automatic test_reset_mid();
      int n_ack = 0;
      bus.LOC_ADDR = 32'hFFFF_0001; bus.LOC_WD = 8'hFF; bus.LOC_WE = 1'b1;
      step();
      bus.LOC_WE = 1'b0;
      step();
      step();
      exp_reg_out[15:8] = 8'hFF;
      tests_run++;
      if (reg_out !== exp_reg_out) begin tests_failed++; $display("[TB] FAIL rstmid_pre: got %h, expected %h", reg_out, exp_reg_out); end
      bus.LOC_WD = 8'h42; bus.LOC_WE = 1'b1;
      step();
      bus.LOC_WE = 1'b0;
      RSTn = 1'b0;
      #1;
      exp_reg_out = '0;
      tests_run++;
      if (reg_out !== exp_reg_out || bus.LOC_ACK !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstmid_async: got regs %h ack %b, expected %h 0", reg_out, bus.LOC_ACK, exp_reg_out); end
      step();
      RSTn = 1'b1;
      for (int c = 0; c < 8; c++) begin
         if (bus.LOC_ACK === 1'b1) n_ack++;
         step();
      end
      tests_run++;
      if (n_ack !== 0) begin tests_failed++; $display("[TB] FAIL rstmid_ack: got %0d acks, expected 0", n_ack); end
      tests_run++;
      if (reg_out !== exp_reg_out) begin tests_failed++; $display("[TB] FAIL rstmid_regs: got %h, expected %h", reg_out, exp_reg_out); end
   endtask

   task automatic test_latency1();
      bus1.LOC_ADDR = 32'hFFFF_0007; bus1.LOC_WD = 8'h5A; bus1.LOC_WE = 1'b1;
      step();
      bus1.LOC_WE = 1'b0;
      tests_run++;
      if (bus1.LOC_ACK !== 1'b1 || reg_wr1 !== 16'h0080) begin tests_failed++; $display("[TB] FAIL lat1_ack: got ack %b wr %h, expected 1 0080", bus1.LOC_ACK, reg_wr1); end
      step();
      exp_reg_out1[63:56] = 8'h5A;
      tests_run++;
      if (bus1.LOC_ACK !== 1'b0 || reg_out1 !== exp_reg_out1) begin tests_failed++; $display("[TB] FAIL lat1_regs: got ack %b regs %h, expected 0 %h", bus1.LOC_ACK, reg_out1, exp_reg_out1); end
      bus1.LOC_ADDR = 32'hFFFF_0010; bus1.LOC_RE = 1'b1;
      step();
      bus1.LOC_RE = 1'b0;
      tests_run++;
      if (bus1.LOC_ACK !== 1'b1 || bus1.LOC_RD !== 8'hE1) begin tests_failed++; $display("[TB] FAIL lat1_status: got ack %b rd %h, expected 1 e1", bus1.LOC_ACK, bus1.LOC_RD); end
      step();
   endtask

   initial begin
      RSTn = 1'b0;
      bus.LOC_ACT = 1'b1;  bus.LOC_ADDR = 32'h0;  bus.LOC_WD = 8'h00;  bus.LOC_WE = 1'b0;  bus.LOC_RE = 1'b0;
      bus1.LOC_ACT = 1'b1; bus1.LOC_ADDR = 32'h0; bus1.LOC_WD = 8'h00; bus1.LOC_WE = 1'b0; bus1.LOC_RE = 1'b0;
      status_in = '0;
      status_in[23:16] = 8'h3C;
      status_in[7:0]   = 8'hC3;
      status_in1 = '0;
      status_in1[7:0] = 8'hE1;
      exp_reg_out  = '0;
      exp_reg_out1 = '0;

      test_reset();
      test_write();
      test_read();
      test_unmapped();
      test_abort();
      test_simultaneous();
      test_act_drop_in_ack();
      test_back_to_back();
      test_reset_mid();
      test_latency1();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
